// File: rtl/iir_sequencer.sv
// iir_sequencer: initiator side of the IIR filter once/done sample handshake.
// Generates a programmable sample tick. On each tick it latches the input sample
// onto x and issues a one-cycle once strobe. It then waits for done, captures y into
// result and pulses result_valid. Overruns (a tick while busy) and timeouts (done
// never returned) are flagged as sticky bits.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   enable          runs the period counter / tick generation
//   period          sample period in clk cycles (0 and 1 behave as 2)
//   clr             clears the sticky flags (and drop_count when present)
//   sample          ADC sample, latched into x on an accepted tick
//   x, once         held sample and start strobe to the filter
//   done, y         completion strobe and result from the filter
//   result          captured filter output; result_valid pulses on update
//   busy            high while a transaction is outstanding (ISSUE/WAIT)
//   overrun         sticky: tick dropped while busy
//   timeout         sticky: WAIT aborted after TIMEOUT cycles
//   drop_count      only with IIR_SEQ_DROPCOUNT_EN: saturating count of
//                   dropped ticks plus timeouts
//
// Optional feature macro: IIR_SEQ_DROPCOUNT_EN
module iir_sequencer #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned DIVWIDTH  = 16,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [DIVWIDTH-1:0]  period,
  input  logic                 clr,
  input  logic [DATAWIDTH-1:0] sample,
  output logic [DATAWIDTH-1:0] x,
  output logic                 once,
  input  logic                 done,
  input  logic [DATAWIDTH-1:0] y,
  output logic [DATAWIDTH-1:0] result,
  output logic                 result_valid,
  output logic                 busy,
  output logic                 overrun,
`ifdef IIR_SEQ_DROPCOUNT_EN
  output logic                 timeout,
  output logic [15:0]          drop_count
`else
  output logic                 timeout
`endif
);

  localparam int unsigned WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t              state;
  logic [DIVWIDTH-1:0] cnt;
  logic [DIVWIDTH-1:0] pm1;
  logic [WW-1:0]       wcnt;
  logic                tick;
  logic                drop;
  logic                to_evt;

  // Terminal count; the live period is compared, so a count already past a
  // shortened period free-runs to all-ones and wraps naturally.
  always_comb begin
    pm1 = period - DIVWIDTH'(1);
    if (period < DIVWIDTH'(2)) pm1 = DIVWIDTH'(1);
  end

  assign tick   = enable && (cnt == pm1);
  assign drop   = tick && (state != ST_IDLE);
  assign to_evt = (state == ST_WAIT) && !done && (wcnt == WLAST);

  // Sample-period counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt <= '0;
    else if (!enable) cnt <= '0;
    else if (tick)    cnt <= '0;
    else              cnt <= cnt + DIVWIDTH'(1);
  end

  // Handshake FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      wcnt         <= '0;
      x            <= '0;
      result       <= '0;
      once         <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      once         <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            x     <= sample;
            once  <= 1'b1;
            busy  <= 1'b1;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wcnt  <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // done takes priority over the timeout abort
          if (done) begin
            result       <= y;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= ST_IDLE;
          end else if (to_evt) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky flags: a set event beats clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (drop)        overrun <= 1'b1;
      else if (clr)    overrun <= 1'b0;
      if (to_evt)      timeout <= 1'b1;
      else if (clr)    timeout <= 1'b0;
    end
  end

`ifdef IIR_SEQ_DROPCOUNT_EN
  logic [1:0]  n_evt;
  logic [16:0] dc_sum;

  assign n_evt  = {1'b0, drop} + {1'b0, to_evt};
  assign dc_sum = {1'b0, drop_count} + 17'(n_evt);

  // Saturating event counter; clr with a coincident event leaves 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             drop_count <= '0;
    else if (clr)        drop_count <= (n_evt != 2'd0) ? 16'd1 : 16'd0;
    else if (dc_sum[16]) drop_count <= 16'hFFFF;
    else                 drop_count <= dc_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_iir_sequencer.sv
// Directed bench for iir_sequencer with a behavioural filter model that answers
// each once with done after a programmable latency (0 = never answers).
module tb_iir_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] period;
  logic        clr;
  logic [31:0] sample;
  logic [31:0] x;
  logic        once;
  logic        done;
  logic [31:0] y;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;
  logic        overrun;
  logic        timeout;
`ifdef IIR_SEQ_DROPCOUNT_EN
  logic [15:0] drop_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int lat      = 0;
  int pend     = 0;
  bit rv_seen  = 1'b0;
  int cyc;

  iir_sequencer #(.DATAWIDTH(32), .DIVWIDTH(16), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .clr(clr),
    .sample(sample), .x(x), .once(once), .done(done), .y(y),
    .result(result), .result_valid(result_valid), .busy(busy),
    .overrun(overrun),
`ifdef IIR_SEQ_DROPCOUNT_EN
    .timeout(timeout), .drop_count(drop_count)
`else
    .timeout(timeout)
`endif
  );

  always #5 clk = ~clk;

  // Filter model: done is high during the cycle 'lat' cycles after once
  always @(negedge clk) begin
    done = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) done = 1'b1;
    end
    if (once && lat > 0) pend = lat;
  end

  always @(negedge clk) if (result_valid) rv_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Advance to the next negedge where once is high; bounded by max cycles
  task automatic wait_once(input int max, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!once && cycles < max);
    check("once_seen", 32'(once), 32'd1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; period = 16'd10; clr = 1'b0;
    sample = '0; y = '0; done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_x", x, 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_once", 32'(once), 32'd0);
    check("rst_rv", 32'(result_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
`ifdef IIR_SEQ_DROPCOUNT_EN
    check("rst_dc", 32'(drop_count), 32'd0);
`endif

    // Basic handshake: period 10, done 3 cycles after once
    sample = 32'h00001234; y = 32'h00000ABC; lat = 3; enable = 1'b1;
    wait_once(30, cyc);
    check("b_x", x, 32'h00001234);
    check("b_busy0", 32'(busy), 32'd1);
    @(negedge clk);
    check("b_once_1cyc", 32'(once), 32'd0);
    check("b_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    check("b_busy2", 32'(busy), 32'd1);
    @(negedge clk);
    check("b_busy3", 32'(busy), 32'd1);
    check("b_rv_early", 32'(result_valid), 32'd0);
    @(negedge clk);
    check("b_busy4", 32'(busy), 32'd0);
    check("b_rv", 32'(result_valid), 32'd1);
    check("b_result", result, 32'h00000ABC);
    sample = 32'h00005678;
    @(negedge clk);
    check("b_rv_pulse", 32'(result_valid), 32'd0);
    check("b_x_hold", x, 32'h00001234);
    wait_once(30, cyc);
    check("b_interval", 32'(cyc + 5), 32'd10);
    check("b_x2", x, 32'h00005678);
    check("b_no_overrun", 32'(overrun), 32'd0);
    enable = 1'b0;
    repeat (8) @(negedge clk);

    // Period clamp: 0 and 1 act as 2; a 2-cycle period always drops every
    // other tick (ISSUE+WAIT spans the next tick), so once repeats every 4
    period = 16'd0; lat = 1; enable = 1'b1;
    wait_once(10, cyc);
    wait_once(10, cyc);
    check("p0_interval", 32'(cyc), 32'd4);
    check("p0_overrun", 32'(overrun), 32'd1);
    period = 16'd1;
    wait_once(10, cyc);
    wait_once(10, cyc);
    check("p1_interval", 32'(cyc), 32'd4);
    enable = 1'b0;
    repeat (6) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("clr_overrun", 32'(overrun), 32'd0);
`ifdef IIR_SEQ_DROPCOUNT_EN
    check("clr_dc", 32'(drop_count), 32'd0);
`endif

    // Overrun: period 4, latency 6 -> tick at once+3 dropped
    period = 16'd4; lat = 6; y = 32'h00003333; sample = 32'hAAAA0001;
    enable = 1'b1;
    wait_once(10, cyc);
    check("o_x", x, 32'hAAAA0001);
    sample = 32'hBBBB0002;
    repeat (3) @(negedge clk);
    check("o_pre", 32'(overrun), 32'd0);
    @(negedge clk);
    check("o_set", 32'(overrun), 32'd1);
    check("o_x_hold", x, 32'hAAAA0001);
`ifdef IIR_SEQ_DROPCOUNT_EN
    check("o_dc", 32'(drop_count), 32'd1);
`endif
    wait_once(10, cyc);
    check("o_interval", 32'(cyc + 4), 32'd8);
    check("o_x2", x, 32'hBBBB0002);

    // Sticky priority: clr at once+1, clr coincident with drop at once+3, clr at once+4
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("s_cleared", 32'(overrun), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check("s_set_wins", 32'(overrun), 32'd1);
`ifdef IIR_SEQ_DROPCOUNT_EN
    check("s_dc_one", 32'(drop_count), 32'd1);
`endif
    @(negedge clk);
    clr = 1'b0;
    check("s_clr_later", 32'(overrun), 32'd0);
`ifdef IIR_SEQ_DROPCOUNT_EN
    check("s_dc_zero", 32'(drop_count), 32'd0);
`endif
    enable = 1'b0;
    repeat (12) @(negedge clk);

    // Timeout: TIMEOUT=16, filter never answers
    lat = 0; y = 32'h0000DEAD; period = 16'd40; enable = 1'b1;
    wait_once(60, cyc);
    rv_seen = 1'b0;
    repeat (16) @(negedge clk);
    check("t_pre", 32'(timeout), 32'd0);
    check("t_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t_set", 32'(timeout), 32'd1);
    check("t_idle", 32'(busy), 32'd0);
    check("t_result_kept", result, 32'h00003333);
    check("t_no_rv", 32'(rv_seen), 32'd0);
`ifdef IIR_SEQ_DROPCOUNT_EN
    check("t_dc", 32'(drop_count), 32'd1);
`endif
    wait_once(60, cyc);
    check("t_reissue", 32'(cyc), 32'd23);
    enable = 1'b0;
    repeat (20) @(negedge clk);

    // Reset two cycles after once, late done must be ignored
    lat = 5; y = 32'h00005555; period = 16'd4; sample = 32'h0000CAFE;
    enable = 1'b1;
    wait_once(20, cyc);
    enable = 1'b0;
    rv_seen = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("r_x", x, 32'h0);
    check("r_busy", 32'(busy), 32'd0);
    check("r_result", result, 32'h0);
    check("r_timeout", 32'(timeout), 32'd0);
    check("r_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("r_no_rv", 32'(rv_seen), 32'd0);
    check("r_result_after", result, 32'h0);
    check("r_busy_after", 32'(busy), 32'd0);
    check("r_once_after", 32'(once), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
